// File: rtl/bcd_cnt_pkg.sv
// bcd_cnt_pkg: shared BCD digit type, digit bounds and load clamp helper.
// Rev 1.0
`default_nettype none

package bcd_cnt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one decimal digit with clear > load > step priority.
// Rev 1.0
`default_nettype none

module bcd_digit_cell
  import bcd_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_nibble,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  assign at_max = (digit == BCD_MAX);
  assign at_min = (digit == BCD_MIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= BCD_MIN;
    end else if (clr) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_clamp(load_nibble);
    end else if (step) begin
      if (up) begin
        digit <= at_max ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= at_min ? BCD_MAX : digit - 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: N-digit BCD up/down counter with wrap/saturate, TC and wrap pulse.
// Optional sticky overflow flag under macro BCD_CNT_OVF_STICKY_EN. Rev 1.0
`default_nettype none

module bcd_updown_counter_n
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  updn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value,
  output logic                  tc,
  output logic                  wrap_pulse
`ifdef BCD_CNT_OVF_STICKY_EN
  ,
  output logic                  ovf_sticky
`endif
);

  localparam logic WRAP_EN = (WRAP != 0);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic              boundary;
  logic              crossing;

  assign boundary = updn ? (&at_max) : (&at_min);
  assign tc       = enable & boundary;
  assign crossing = tc & ~clr & ~load;

  // In saturate mode the whole chain is frozen when the count would cross.
  assign step[0] = enable & ~(boundary & ~WRAP_EN);

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      if (k > 0) begin : g_ripple
        assign step[k] = step[k-1] & (updn ? at_max[k-1] : at_min[k-1]);
      end

      bcd_digit_cell u_cell (
        .clk         (clk),
        .rst         (rst),
        .step        (step[k]),
        .up          (updn),
        .load        (load),
        .load_nibble (load_val[4*k +: 4]),
        .clr         (clr),
        .digit       (value[4*k +: 4]),
        .at_max      (at_max[k]),
        .at_min      (at_min[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= WRAP_EN & crossing;
    end
  end

`ifdef BCD_CNT_OVF_STICKY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      ovf_sticky <= 1'b0;
    end else if (crossing) begin
      ovf_sticky <= 1'b1;
    end
  end
`else
  // Without the sticky option no overflow history is kept.
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_counter_n.sv
// tb_bcd_updown_counter_n: directed checks of wrap (u_w) and saturate (u_s) 2-digit counters.
// Rev 1.0
`default_nettype none

module tb_bcd_updown_counter_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       updn;
  logic       load;
  logic [7:0] load_val;
  logic       clr;
  logic [7:0] value_w, value_s;
  logic       tc_w, tc_s;
  logic       wp_w, wp_s;
`ifdef BCD_CNT_OVF_STICKY_EN
  logic       ovf_w, ovf_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(2), .WRAP(1)) u_w (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .updn       (updn),
    .load       (load),
    .load_val   (load_val),
    .clr        (clr),
    .value      (value_w),
    .tc         (tc_w),
    .wrap_pulse (wp_w)
`ifdef BCD_CNT_OVF_STICKY_EN
    ,
    .ovf_sticky (ovf_w)
`endif
  );

  bcd_updown_counter_n #(.DIGITS(2), .WRAP(0)) u_s (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .updn       (updn),
    .load       (load),
    .load_val   (load_val),
    .clr        (clr),
    .value      (value_s),
    .tc         (tc_s),
    .wrap_pulse (wp_s)
`ifdef BCD_CNT_OVF_STICKY_EN
    ,
    .ovf_sticky (ovf_s)
`endif
  );

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((n / 10) % 10);
    ones = 4'(n % 10);
    return {tens, ones};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input logic [7:0] v, input logic t, input logic p);
    check({tag, " w.value"}, 32'(value_w), 32'(v));
    check({tag, " w.tc"}, 32'(tc_w), 32'(t));
    check({tag, " w.pulse"}, 32'(wp_w), 32'(p));
  endtask

  task automatic chk_s(input string tag, input logic [7:0] v, input logic t, input logic p);
    check({tag, " s.value"}, 32'(value_s), 32'(v));
    check({tag, " s.tc"}, 32'(tc_s), 32'(t));
    check({tag, " s.pulse"}, 32'(wp_s), 32'(p));
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; updn = 1'b1; load = 1'b0; load_val = 8'h00; clr = 1'b0;
    tick(); tick();
    chk_w("reset", 8'h00, 1'b0, 1'b0);
    chk_s("reset", 8'h00, 1'b0, 1'b0);

    // Count up 100 cycles: wrap instance rolls 99->00, saturate instance sticks at 99.
    rst = 1'b1; enable = 1'b1; updn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk_w("up", to_bcd(i), (i == 99), 1'b0);
      chk_s("up", to_bcd(i), (i == 99), 1'b0);
      tick();
    end
    chk_w("up wrap", 8'h00, 1'b0, 1'b1);
    chk_s("up sat", 8'h99, 1'b1, 1'b0);
    tick();
    chk_w("up after wrap", 8'h01, 1'b0, 1'b0);
    chk_s("up sat hold", 8'h99, 1'b1, 1'b0);

    clr = 1'b1; tick(); clr = 1'b0;
    chk_w("clear", 8'h00, 1'b0, 1'b0);
    updn = 1'b0; tick();
    chk_w("down wrap", 8'h99, 1'b0, 1'b1);
    chk_s("down sat", 8'h00, 1'b1, 1'b0);
    tick();
    chk_w("down 98", 8'h98, 1'b0, 1'b0);
    chk_s("down sat hold", 8'h00, 1'b1, 1'b0);

    enable = 1'b0; load = 1'b1; load_val = 8'h98; tick();
    load = 1'b0; enable = 1'b1; updn = 1'b1;
    check("load98 w", 32'(value_w), 32'h98);
    check("load98 s", 32'(value_s), 32'h98);
    tick();
    chk_w("sat seq1", 8'h99, 1'b1, 1'b0);
    chk_s("sat seq1", 8'h99, 1'b1, 1'b0);
    tick();
    chk_w("sat seq2", 8'h00, 1'b0, 1'b1);
    chk_s("sat seq2", 8'h99, 1'b1, 1'b0);
    tick();
    chk_w("sat seq3", 8'h01, 1'b0, 1'b0);
    chk_s("sat seq3", 8'h99, 1'b1, 1'b0);

    enable = 1'b0; load = 1'b1; load_val = 8'hAF; tick();
    check("clamp w", 32'(value_w), 32'h99);
    check("clamp s", 32'(value_s), 32'h99);
    clr = 1'b1; tick(); clr = 1'b0;
    check("load+clr w", 32'(value_w), 32'h00);
    check("load+clr s", 32'(value_s), 32'h00);
    enable = 1'b1; load_val = 8'h42; tick();
    chk_w("load+en", 8'h42, 1'b0, 1'b0);
    chk_s("load+en", 8'h42, 1'b0, 1'b0);

    enable = 1'b0; load_val = 8'h57; tick(); load = 1'b0;
    check("load57", 32'(value_w), 32'h57);
    #3 rst = 1'b0;
    #1;
    chk_w("async rst", 8'h00, 1'b0, 1'b0);
    chk_s("async rst", 8'h00, 1'b0, 1'b0);
`ifdef BCD_CNT_OVF_STICKY_EN
    check("sticky rst w", 32'(ovf_w), 32'h0);
    check("sticky rst s", 32'(ovf_s), 32'h0);
`endif
    #1 rst = 1'b1; enable = 1'b1; updn = 1'b1;
    tick();
    check("resume w", 32'(value_w), 32'h01);
    check("resume s", 32'(value_s), 32'h01);

`ifdef BCD_CNT_OVF_STICKY_EN
    enable = 1'b0; load = 1'b1; load_val = 8'h99; tick();
    load = 1'b0; enable = 1'b1;
    check("sticky pre w", 32'(ovf_w), 32'h0);
    tick();
    check("sticky wrap w", 32'(ovf_w), 32'h1);
    check("sticky blocked s", 32'(ovf_s), 32'h1);
    enable = 1'b0; load = 1'b1; load_val = 8'h12; tick(); load = 1'b0;
    check("sticky load value", 32'(value_w), 32'h12);
    check("sticky after load w", 32'(ovf_w), 32'h1);
    check("sticky after load s", 32'(ovf_s), 32'h1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("sticky clr w", 32'(ovf_w), 32'h0);
    check("sticky clr s", 32'(ovf_s), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
